// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : alu_pkg
// Description : Shared constants and types for the ALU issue controller.
//               Holds the ALU operation codes, the MIPS opcode and funct
//               values the controller understands, the controller state
//               enum and the decoder result struct.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // ALU operation codes driven on alu_operation
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  // Unused code; the ALU returns zero for it, so it is a safe idle value
  localparam logic [3:0] OP_NONE = 4'b1111;

  // Instruction opcodes
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;

  // R-type function fields
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Source of ALU operand 2
  typedef enum logic [1:0] {
    RD2_SRC_B = 2'd0,
    RD2_SEXT  = 2'd1,
    RD2_ZEXT  = 2'd2
  } rd2_sel_t;

  // Decoder result
  typedef struct packed {
    logic [3:0] operation;
    rd2_sel_t   rd2_sel;
    logic       is_branch;
    logic       illegal;
  } dec_t;

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : alu_issue_ctrl_if
// Description : Bundles the instruction input handshake, the ALU operand /
//               result bus and the response handshake of alu_issue_ctrl.
//   slave  modport : view of the issue controller itself
//   master modport : view of the surrounding datapath (instruction source,
//                    ALU and response consumer)
// Signals     : in_valid/in_ready, opcode, funct, src_a, src_b, imm,
//               alu_read1, alu_read2, alu_operation, alu_result,
//               out_valid/out_ready, out_result, out_zero,
//               out_branch_taken, out_illegal
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [IMM_W-1:0] imm;

  logic [WIDTH-1:0] alu_read1;
  logic [WIDTH-1:0] alu_read2;
  logic [3:0]       alu_operation;
  logic [WIDTH-1:0] alu_result;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_branch_taken;
  logic             out_illegal;

  modport slave (
    input  in_valid, opcode, funct, src_a, src_b, imm, alu_result, out_ready,
    output in_ready, alu_read1, alu_read2, alu_operation,
           out_valid, out_result, out_zero, out_branch_taken, out_illegal
  );

  modport master (
    output in_valid, opcode, funct, src_a, src_b, imm, alu_result, out_ready,
    input  in_ready, alu_read1, alu_read2, alu_operation,
           out_valid, out_result, out_zero, out_branch_taken, out_illegal
  );
endinterface
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decode
// Description : Combinational opcode/funct decoder. Produces the ALU
//               operation code, the operand-2 source (rt, sign- or
//               zero-extended immediate), a branch flag and an illegal flag.
// Ports       : opcode (in, 6)  instruction opcode
//               funct  (in, 6)  R-type function field
//               dec    (out)    decoded fields (dec_t)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec.operation = OP_NONE;
    dec.rd2_sel   = RD2_SRC_B;
    dec.is_branch = 1'b0;
    dec.illegal   = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_AND:  dec.operation = OP_AND;
          FN_OR:   dec.operation = OP_OR;
          FN_ADD:  dec.operation = OP_ADD;
          FN_SUB:  dec.operation = OP_SUB;
          FN_SLT:  dec.operation = OP_SLT;
          FN_NOR:  dec.operation = OP_NOR;
          default: dec.illegal   = 1'b1;
        endcase
      end
      OPC_ADDI: begin
        dec.operation = OP_ADD;
        dec.rd2_sel   = RD2_SEXT;
      end
      OPC_SLTI: begin
        dec.operation = OP_SLT;
        dec.rd2_sel   = RD2_SEXT;
      end
      OPC_ANDI: begin
        dec.operation = OP_AND;
        dec.rd2_sel   = RD2_ZEXT;
      end
      OPC_ORI: begin
        dec.operation = OP_OR;
        dec.rd2_sel   = RD2_ZEXT;
      end
      OPC_BEQ: begin
        // Equality is tested by subtracting and checking for zero
        dec.operation = OP_SUB;
        dec.is_branch = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Initiator side of the registered ALU. Accepts one decoded
//               instruction in IDLE, registers operation and operands onto
//               the ALU ports, waits for the ALU's registered result,
//               captures result / zero / branch-taken and presents them on a
//               valid/ready response until accepted.
// Parameters  : WIDTH - operand/result width
//               IMM_W - immediate width (extended to WIDTH)
// Ports       : clk   (in)  rising-edge clock
//               rst_n (in)  asynchronous active-low reset
//               bus   (alu_issue_ctrl_if.slave) handshakes and ALU bus
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IMM_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_issue_ctrl_if.slave    bus
);

  state_t           state, state_nxt;
  dec_t             dec;
  logic             accept;
  logic             capture;
  logic             load_illegal;
  logic [WIDTH-1:0] read2_nxt;
  logic             result_zero;

  logic [WIDTH-1:0] read1_q;
  logic [WIDTH-1:0] read2_q;
  logic [3:0]       op_q;
  logic             branch_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             taken_q;
  logic             illegal_q;

  alu_op_decode u_decode (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .dec    (dec)
  );

  // Operand 2 source selection and immediate extension
  always_comb begin
    case (dec.rd2_sel)
      RD2_SEXT: read2_nxt = {{(WIDTH-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
      RD2_ZEXT: read2_nxt = {{(WIDTH-IMM_W){1'b0}}, bus.imm};
      default:  read2_nxt = bus.src_b;
    endcase
  end

  assign result_zero = (bus.alu_result == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and load-enable logic
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    capture      = 1'b0;
    load_illegal = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          if (dec.illegal) begin
            // Illegal instructions bypass the ALU entirely
            load_illegal = 1'b1;
            state_nxt    = ST_DONE;
          end else begin
            accept    = 1'b1;
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        capture   = 1'b1;
        state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ALU-side operand registers: change only on a legal accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read1_q  <= '0;
      read2_q  <= '0;
      op_q     <= OP_NONE;
      branch_q <= 1'b0;
    end else if (accept) begin
      read1_q  <= bus.src_a;
      read2_q  <= read2_nxt;
      op_q     <= dec.operation;
      branch_q <= dec.is_branch;
    end
  end

  // Response capture registers: held stable throughout DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      zero_q    <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (capture) begin
      result_q  <= bus.alu_result;
      zero_q    <= result_zero;
      taken_q   <= branch_q && result_zero;
      illegal_q <= 1'b0;
    end else if (load_illegal) begin
      result_q  <= '0;
      zero_q    <= 1'b1;
      taken_q   <= 1'b0;
      illegal_q <= 1'b1;
    end
  end

  assign bus.in_ready         = (state == ST_IDLE);
  assign bus.out_valid        = (state == ST_DONE);
  assign bus.alu_read1        = read1_q;
  assign bus.alu_read2        = read2_q;
  assign bus.alu_operation    = op_q;
  assign bus.out_result       = result_q;
  assign bus.out_zero         = zero_q;
  assign bus.out_branch_taken = taken_q;
  assign bus.out_illegal      = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Self-checking bench for alu_issue_ctrl. Contains a registered
//               ALU model on the ALU bus and an instruction-level reference
//               model that computes the architectural result of each
//               instruction directly from its meaning.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  alu_issue_ctrl_if #(.WIDTH(32), .IMM_W(16)) bus ();

  alu_issue_ctrl #(.WIDTH(32), .IMM_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU: samples its operands on every rising edge
  always @(posedge clk) begin
    case (bus.alu_operation)
      4'b0000: bus.alu_result <= bus.alu_read1 & bus.alu_read2;
      4'b0001: bus.alu_result <= bus.alu_read1 | bus.alu_read2;
      4'b0010: bus.alu_result <= bus.alu_read1 + bus.alu_read2;
      4'b0110: bus.alu_result <= bus.alu_read1 - bus.alu_read2;
      4'b0111: bus.alu_result <= ($signed(bus.alu_read1) < $signed(bus.alu_read2)) ? 32'd1 : 32'd0;
      4'b1100: bus.alu_result <= ~(bus.alu_read1 | bus.alu_read2);
      default: bus.alu_result <= 32'd0;
    endcase
  end

  typedef struct packed {
    logic        illegal;
    logic [3:0]  op;
    logic [31:0] rd2;
    logic [31:0] res;
    logic        br;
  } exp_t;

  // Instruction-level reference: what the instruction should produce
  function automatic exp_t ref_model(input logic [5:0] opc, input logic [5:0] fn,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic [15:0] im);
    exp_t e;
    logic [31:0] sx;
    logic [31:0] zx;
    sx = {{16{im[15]}}, im};
    zx = {16'h0000, im};
    e = '0;
    e.rd2 = b;
    case (opc)
      6'h00: begin
        case (fn)
          6'h20: begin e.op = 4'b0010; e.res = a + b; end
          6'h22: begin e.op = 4'b0110; e.res = a - b; end
          6'h24: begin e.op = 4'b0000; e.res = a & b; end
          6'h25: begin e.op = 4'b0001; e.res = a | b; end
          6'h27: begin e.op = 4'b1100; e.res = ~(a | b); end
          6'h2a: begin e.op = 4'b0111; e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
          default: e.illegal = 1'b1;
        endcase
      end
      6'h04: begin e.op = 4'b0110; e.res = a - b; e.br = (a == b); end
      6'h08: begin e.op = 4'b0010; e.rd2 = sx; e.res = a + sx; end
      6'h0a: begin e.op = 4'b0111; e.rd2 = sx; e.res = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0; end
      6'h0c: begin e.op = 4'b0000; e.rd2 = zx; e.res = a & zx; end
      6'h0d: begin e.op = 4'b0001; e.rd2 = zx; e.res = a | zx; end
      default: e.illegal = 1'b1;
    endcase
    if (e.illegal) e.res = 32'd0;
    return e;
  endfunction

  // Values last issued onto the ALU bus; they must persist between instructions
  logic [3:0]  last_op;
  logic [31:0] last_rd1;
  logic [31:0] last_rd2;

  logic [5:0] opcs [6];
  logic [5:0] fncs [6];

  // One full instruction: accept, latency, response, backpressure, release.
  // Entered and left on a falling edge with the controller in IDLE.
  task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [15:0] im, input int hold);
    exp_t e;
    e = ref_model(opc, fn, a, b, im);
    total++; if (bus.in_ready !== 1'b1) $display("FAIL in_ready_idle: got %b want 1", bus.in_ready); else passed++;
    bus.in_valid = 1'b1; bus.opcode = opc; bus.funct = fn;
    bus.src_a = a; bus.src_b = b; bus.imm = im;
    @(negedge clk);
    // Scramble inputs: nothing may be re-sampled after the accept edge
    bus.in_valid = 1'b0; bus.opcode = 6'($urandom); bus.funct = 6'($urandom);
    bus.src_a = $urandom; bus.src_b = $urandom; bus.imm = 16'($urandom);
    if (!e.illegal) begin
      total++; if (bus.alu_operation !== e.op) $display("FAIL alu_operation: got %b want %b", bus.alu_operation, e.op); else passed++;
      total++; if (bus.alu_read1 !== a) $display("FAIL alu_read1: got %h want %h", bus.alu_read1, a); else passed++;
      total++; if (bus.alu_read2 !== e.rd2) $display("FAIL alu_read2: got %h want %h", bus.alu_read2, e.rd2); else passed++;
      total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) $display("FAIL issue_hs: got out_valid=%b in_ready=%b want 0/0", bus.out_valid, bus.in_ready); else passed++;
      last_op = e.op; last_rd1 = a; last_rd2 = e.rd2;
      bus.in_valid = 1'b1;
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) $display("FAIL wait_hs: got out_valid=%b in_ready=%b want 0/0", bus.out_valid, bus.in_ready); else passed++;
      @(negedge clk);
    end else begin
      total++; if (bus.alu_operation !== last_op || bus.alu_read1 !== last_rd1 || bus.alu_read2 !== last_rd2)
        $display("FAIL illegal_alu_hold: got %b/%h/%h want %b/%h/%h", bus.alu_operation, bus.alu_read1, bus.alu_read2, last_op, last_rd1, last_rd2); else passed++;
    end
    total++; if (bus.out_valid !== 1'b1) $display("FAIL out_valid_latency: got %b want 1", bus.out_valid); else passed++;
    total++; if (bus.out_result !== e.res) $display("FAIL out_result: got %h want %h (opc %h fn %h)", bus.out_result, e.res, opc, fn); else passed++;
    total++; if (bus.out_zero !== (e.res == 32'd0)) $display("FAIL out_zero: got %b want %b", bus.out_zero, (e.res == 32'd0)); else passed++;
    total++; if (bus.out_branch_taken !== e.br) $display("FAIL out_branch_taken: got %b want %b", bus.out_branch_taken, e.br); else passed++;
    total++; if (bus.out_illegal !== e.illegal) $display("FAIL out_illegal: got %b want %b", bus.out_illegal, e.illegal); else passed++;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_result !== e.res || bus.out_illegal !== e.illegal || bus.out_branch_taken !== e.br)
        $display("FAIL backpressure_hold: got v=%b r=%b res=%h ill=%b br=%b want 1/0/%h/%b/%b", bus.out_valid, bus.in_ready, bus.out_result, bus.out_illegal, bus.out_branch_taken, e.res, e.illegal, e.br); else passed++;
      total++; if (bus.alu_operation !== last_op || bus.alu_read1 !== last_rd1) $display("FAIL done_alu_hold: got %b/%h want %b/%h", bus.alu_operation, bus.alu_read1, last_op, last_rd1); else passed++;
    end
    // Release together with a pending input: the input must not be taken here
    bus.in_valid = 1'b1; bus.opcode = 6'h00; bus.funct = 6'h20;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL release: got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); else passed++;
    total++; if (bus.alu_operation !== last_op || bus.alu_read1 !== last_rd1 || bus.alu_read2 !== last_rd2)
      $display("FAIL release_no_accept: got %b/%h/%h want %b/%h/%h", bus.alu_operation, bus.alu_read1, bus.alu_read2, last_op, last_rd1, last_rd2); else passed++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) $display("FAIL reset_hs: got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid); else passed++;
    total++; if (bus.alu_operation !== 4'b1111) $display("FAIL reset_op: got %b want 1111", bus.alu_operation); else passed++;
    total++; if (bus.alu_read1 !== 32'd0 || bus.alu_read2 !== 32'd0) $display("FAIL reset_operands: got %h/%h want 0/0", bus.alu_read1, bus.alu_read2); else passed++;
    total++; if ({bus.out_result, bus.out_zero, bus.out_branch_taken, bus.out_illegal} !== 35'd0)
      $display("FAIL reset_outs: got %h/%b/%b/%b want 0", bus.out_result, bus.out_zero, bus.out_branch_taken, bus.out_illegal); else passed++;
    rst_n = 1'b1;
    last_op = 4'b1111; last_rd1 = 32'd0; last_rd2 = 32'd0;
    @(negedge clk);
  endtask

  task automatic test_add();
    run_instr(6'h00, 6'h20, 32'd5, 32'd7, 16'h0000, 0);
  endtask

  task automatic test_sub_zero();
    run_instr(6'h00, 6'h22, 32'h1234, 32'h1234, 16'h0000, 1);
  endtask

  task automatic test_beq();
    run_instr(6'h04, 6'h00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 16'h0003, 0);
    run_instr(6'h04, 6'h00, 32'd3, 32'd4, 16'h0000, 0);
  endtask

  task automatic test_imm_ext();
    run_instr(6'h08, 6'h00, 32'd1, 32'h5555_5555, 16'hFFFF, 0);
    run_instr(6'h0d, 6'h00, 32'd0, 32'h5555_5555, 16'h8000, 0);
    run_instr(6'h0a, 6'h00, 32'hFFFF_FFFE, 32'd0, 16'hFFFF, 0);
    run_instr(6'h0c, 6'h00, 32'hFFFF_FFFF, 32'd0, 16'h8001, 0);
  endtask

  task automatic test_illegal();
    run_instr(6'h00, 6'h00, 32'd9, 32'd9, 16'h0000, 0);
    run_instr(6'h3f, 6'h20, 32'd1, 32'd2, 16'h0001, 1);
  endtask

  task automatic test_backpressure();
    run_instr(6'h00, 6'h27, 32'h0F0F_0000, 32'h0000_00F0, 16'h0000, 5);
  endtask

  task automatic test_reset_mid();
    bus.in_valid = 1'b1; bus.opcode = 6'h00; bus.funct = 6'h20;
    bus.src_a = 32'd100; bus.src_b = 32'd23; bus.imm = 16'h0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    // Controller is now in WAIT
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL midreset_hs: got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); else passed++;
    total++; if (bus.alu_operation !== 4'b1111 || bus.alu_read1 !== 32'd0 || bus.alu_read2 !== 32'd0)
      $display("FAIL midreset_alu: got %b/%h/%h want 1111/0/0", bus.alu_operation, bus.alu_read1, bus.alu_read2); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    last_op = 4'b1111; last_rd1 = 32'd0; last_rd2 = 32'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL midreset_no_resp: got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); else passed++;
    end
  endtask

  task automatic test_random();
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    for (int n = 0; n < 60; n++) begin
      int k;
      k = $urandom_range(0, 7);
      opc = (k < 6) ? opcs[k] : 6'($urandom);
      fn  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fncs[$urandom_range(0, 5)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_instr(opc, fn, a, b, 16'($urandom), $urandom_range(0, 3));
    end
  endtask

  initial begin
    passed = 0; total = 0;
    opcs = '{6'h00, 6'h04, 6'h08, 6'h0a, 6'h0c, 6'h0d};
    fncs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a};
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.opcode = 6'h0; bus.funct = 6'h0;
    bus.src_a = 32'd0; bus.src_b = 32'd0; bus.imm = 16'h0;
    test_reset();
    test_add();
    test_sub_zero();
    test_beq();
    test_imm_ext();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
